// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache line ports and one line-level memory port.
// One transaction at a time: IDLE -> BUSY (memory) -> RESP (client pulse) -> DONE -> IDLE.
module cacheline_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic [ADDR_W-1:0] mem_raddr,
   input  logic              mem_resp
);

   localparam int OFF_W = $clog2(LINE_W / 8);

   typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;

   state_t            state, state_nxt;
   logic              last_d;
   logic              owner_d;
   logic              op_write;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] i_line;
   logic [LINE_W-1:0] d_line;
   logic              req_i, req_d;
   logic              grant, grant_d, accept;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_d   = 1'b0;
      accept    = 1'b0;
      req_i     = i_read;
      req_d     = d_read | d_write;
      case (state)
         IDLE: begin
            if (req_i || req_d) begin
               grant = 1'b1;
               // On a tie, the client that did not win last time goes first.
               grant_d   = req_d & (~req_i | ~last_d);
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            // Read completions must carry our line's address; stray tags are dropped.
            if (mem_resp && (op_write || (mem_raddr == addr_q))) begin
               accept    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_d    <= 1'b0;
         owner_d   <= 1'b0;
         op_write  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_line    <= '0;
         d_line    <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         i_resp    <= 1'b0;
         d_resp    <= 1'b0;
      end else begin
         if (grant) begin
            owner_d   <= grant_d;
            last_d    <= grant_d;
            addr_q    <= line_align(grant_d ? d_addr : i_addr);
            op_write  <= grant_d & d_write;
            wdata_q   <= d_wdata;
            mem_read  <= ~(grant_d & d_write);
            mem_write <= grant_d & d_write;
         end
         if (accept) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_resp    <= ~owner_d;
            d_resp    <= owner_d;
            if (!op_write) begin
               if (owner_d) d_line <= mem_rdata;
               else         i_line <= mem_rdata;
            end
         end
         if (state == RESP) begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
         end
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_rdata   = i_line;
   assign d_rdata   = d_line;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: a transaction-level model predicts grant order,
// memory requests and client responses; a memory responder and a response monitor check them.
module tb_cacheline_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] i_addr, d_addr, mem_addr, mem_raddr;
   logic              i_read, i_resp, d_read, d_write, d_resp;
   logic              mem_read, mem_write, mem_resp;
   logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

   cacheline_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_raddr(mem_raddr),
      .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      bit                wr;
      logic [LINE_W-1:0] wdata;
   } mem_exp_t;

   typedef struct {
      bit                d;
      logic [LINE_W-1:0] i_line;
      logic [LINE_W-1:0] d_line;
   } resp_exp_t;

   mem_exp_t  mem_q[$];
   resp_exp_t resp_q[$];

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   bit                last_d = 1'b0;
   logic [LINE_W-1:0] model_i = '0;
   logic [LINE_W-1:0] model_d = '0;
   bit                hold_off = 1'b0;

   function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      logic [LINE_W-1:0] r;
      for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = a ^ (32'h9E37_79B9 * (k + 1));
      return r;
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Response monitor: every client pulse must match the next predicted completion.
   always @(negedge clk) begin
      if (!rst && (i_resp || d_resp)) begin
         if (resp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: got i_resp=%b d_resp=%b expected none", i_resp, d_resp);
         end else begin
            resp_exp_t e;
            e = resp_q.pop_front();
            chk1("resp_i_client", i_resp, ~e.d);
            chk1("resp_d_client", d_resp, e.d);
            chk("i_rdata", i_rdata, e.i_line);
            chk("d_rdata", d_rdata, e.d_line);
         end
      end
   end

   // Memory responder: checks each line request, then completes it after a random delay.
   initial begin
      mem_resp  = 1'b0;
      mem_raddr = '0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst && !hold_off && (mem_read || mem_write)) begin
            if (mem_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_mem_req: got addr=%h rd=%b wr=%b expected none",
                        mem_addr, mem_read, mem_write);
            end else begin
               mem_exp_t m;
               int       dly;
               m = mem_q.pop_front();
               chk32("mem_addr", mem_addr, m.addr);
               chk1("mem_write", mem_write, m.wr);
               chk1("mem_read", mem_read, ~m.wr);
               if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
               dly = $urandom_range(0, 3);
               for (int k = 0; k < dly; k++) begin
                  @(negedge clk);
                  chk1("mem_req_held", mem_read | mem_write, 1'b1);
                  if (m.wr) chk("mem_wdata_stable", mem_wdata, m.wdata);
               end
               if (!m.wr && $urandom_range(0, 2) == 0) begin
                  @(posedge clk); #1;
                  mem_resp  = 1'b1;
                  mem_raddr = m.addr ^ 32'h100;
                  mem_rdata = line_of(mem_raddr);
                  @(posedge clk); #1;
                  mem_resp  = 1'b0;
                  mem_rdata = rand_line();
                  @(negedge clk);
                  chk1("bogus_tag_still_busy", mem_read, 1'b1);
                  chk1("bogus_tag_no_resp", i_resp | d_resp, 1'b0);
               end
               @(posedge clk); #1;
               mem_resp  = 1'b1;
               mem_raddr = m.addr;
               mem_rdata = line_of(m.addr);
               @(posedge clk); #1;
               mem_resp  = 1'b0;
               mem_raddr = '0;
               mem_rdata = rand_line();
               @(negedge clk);
               chk1("mem_req_drop", mem_read | mem_write, 1'b0);
               chk1("resp_latency", i_resp | d_resp, 1'b1);
            end
         end
      end
   end

   task automatic client_i(input logic [ADDR_W-1:0] a);
      bit got = 1'b0;
      @(posedge clk); #1;
      i_addr = a;
      i_read = 1'b1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (i_resp) got = 1'b1;
      end
      chk1("i_resp_timeout", got, 1'b1);
      @(posedge clk); #1;
      i_read = 1'b0;
   endtask

   task automatic client_d(input logic [ADDR_W-1:0] a, input int dop, input logic [LINE_W-1:0] wd);
      bit got = 1'b0;
      @(posedge clk); #1;
      d_addr  = a;
      d_read  = (dop != 1);
      d_write = (dop != 0);
      d_wdata = wd;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (d_resp) got = 1'b1;
      end
      chk1("d_resp_timeout", got, 1'b1);
      @(posedge clk); #1;
      d_read  = 1'b0;
      d_write = 1'b0;
   endtask

   // kind: 0 = I only, 1 = D only, 2 = both together. dop: 0 read, 1 write, 2 read+write.
   task automatic run_scn(input int kind, input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                          input int dop, input logic [LINE_W-1:0] wd);
      bit order[$];
      if (kind == 0)       order = '{1'b0};
      else if (kind == 1)  order = '{1'b1};
      else if (!last_d)    order = '{1'b1, 1'b0};
      else                 order = '{1'b0, 1'b1};
      foreach (order[n]) begin
         mem_exp_t  m;
         resp_exp_t r;
         if (order[n]) begin
            m.addr  = da & ~32'h1F;
            m.wr    = (dop != 0);
            m.wdata = wd;
            if (!m.wr) model_d = line_of(m.addr);
         end else begin
            m.addr  = ia & ~32'h1F;
            m.wr    = 1'b0;
            m.wdata = '0;
            model_i = line_of(m.addr);
         end
         mem_q.push_back(m);
         r.d      = order[n];
         r.i_line = model_i;
         r.d_line = model_d;
         resp_q.push_back(r);
         last_d = order[n];
      end
      fork
         if (kind != 1) client_i(ia);
         if (kind != 0) client_d(da, dop, wd);
      join
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_addr = '0; i_read = 1'b0;
      d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk1("rst_mem_read", mem_read, 1'b0);
      chk1("rst_mem_write", mem_write, 1'b0);
      chk1("rst_i_resp", i_resp, 1'b0);
      chk1("rst_d_resp", d_resp, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_i_rdata", i_rdata, '0);
      chk("rst_d_rdata", d_rdata, '0);

      run_scn(0, 32'h0000_1234, 32'h0, 0, '0);
      run_scn(2, 32'h0000_4000, 32'h0000_5008, 0, '0);
      run_scn(2, 32'h0000_6010, 32'h0000_7030, 0, '0);
      run_scn(1, 32'h0, 32'h8000_0040, 1, {8{32'hDEAD_BEEF}});
      run_scn(1, 32'h0, 32'h0000_0100, 2, rand_line());

      // Reset in the middle of a read that memory never answers.
      hold_off = 1'b1;
      @(posedge clk); #1;
      i_addr = 32'h0000_0300;
      i_read = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk1("busy_mem_read", mem_read, 1'b1);
      chk32("busy_mem_addr", mem_addr, 32'h0000_0300);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      i_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk1("midrst_mem_read", mem_read, 1'b0);
      chk1("midrst_mem_write", mem_write, 1'b0);
      chk1("midrst_i_resp", i_resp, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_d   = 1'b0;
      model_i  = '0;
      model_d  = '0;
      hold_off = 1'b0;
      @(negedge clk);
      chk1("postrst_i_resp", i_resp, 1'b0);
      chk("postrst_i_rdata", i_rdata, '0);
      run_scn(0, 32'h0000_0344, 32'h0, 0, '0);

      for (int s = 0; s < 60; s++) begin
         run_scn($urandom_range(0, 2), $urandom, $urandom, $urandom_range(0, 2), rand_line());
      end

      repeat (4) @(posedge clk);
      n_vec++;
      if (mem_q.size() != 0 || resp_q.size() != 0) begin
         n_err++;
         $display("FAIL leftover_expectations: got mem=%0d resp=%0d expected 0 0",
                  mem_q.size(), resp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
